// File: rtl/slc3_arb_pkg.sv
// Shared types and constants for the SLC-3 SRAM arbiter.
package slc3_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker; the last-owner history is held by the caller.
module arb_rr2
   import slc3_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |req;
      grant_id    = OWNER_CPU;
      // On a tie the requester that did not go last wins, so neither side starves.
      if (req == 2'b11)
         grant_id = ~last_owner;
      else if (req[OWNER_DMA])
         grant_id = OWNER_DMA;
   end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Shares one SRAM between the SLC-3 CPU and a DMA/loader port: round-robin grant,
// fixed wait states, one-cycle ack pulse per completed access.
module slc3_mem_arbiter
   import slc3_arb_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_oe,
   output logic              sram_we,
   output logic              busy,
   output logic              owner
);

   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_owner_q, last_owner_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              grant_valid, grant_id;

   arb_rr2 u_rr (
      .req         ({dma_req, cpu_req}),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d = grant_id;
               we_d    = (grant_id == OWNER_DMA) ? dma_we    : cpu_we;
               addr_d  = (grant_id == OWNER_DMA) ? dma_addr  : cpu_addr;
               wdata_d = (grant_id == OWNER_DMA) ? dma_wdata : cpu_wdata;
               cnt_d   = CNT_W'(WAIT_STATES);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  if (owner_q == OWNER_DMA) dma_rdata_d = sram_rdata;
                  else                      cpu_rdata_d = sram_rdata;
               end
               last_owner_d = owner_q;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_owner_q <= OWNER_DMA;
         owner_q      <= OWNER_CPU;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   // Enables decode straight from the state flop, so they fall as soon as Reset clears it.
   assign sram_oe    = (state_q == ACCESS) && !we_q;
   assign sram_we    = (state_q == ACCESS) &&  we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign cpu_ack    = (state_q == DONE) && (owner_q == OWNER_CPU);
   assign dma_ack    = (state_q == DONE) && (owner_q == OWNER_DMA);
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign busy       = (state_q != IDLE);
   assign owner      = owner_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Scoreboard bench for slc3_mem_arbiter (WAIT_STATES = 1): directed vectors, ack monitor.
module tb_slc3_mem_arbiter;
  import slc3_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WS = 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, sram_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, sram_wdata, sram_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_ack, dma_ack, sram_oe, sram_we, busy, owner;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] own_rdata;
    logic [DW-1:0] other_rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_oe(sram_oe), .sram_we(sram_we), .busy(busy), .owner(owner)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // SRAM read model: 0x0010 holds 0xBEEF, every other word reads as ~addr.
  assign sram_rdata = (sram_addr == 16'h0010) ? 16'hBEEF : ~sram_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic pins(input string tag, input logic b, input logic oe, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd);
    check({tag, "_busy"},  32'(busy),       32'(b));
    check({tag, "_oe"},    32'(sram_oe),    32'(oe));
    check({tag, "_we"},    32'(sram_we),    32'(we));
    check({tag, "_addr"},  32'(sram_addr),  32'(a));
    check({tag, "_wdata"}, 32'(sram_wdata), 32'(wd));
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cpu_ack || dma_ack) && n < 12);
    check({tag, "_ack_seen"}, 32'(cpu_ack | dma_ack), 32'd1);
  endtask

  // Monitor: every ack pops one expectation and compares owner and both rdata registers.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (!Reset && (cpu_ack || dma_ack)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 32'({cpu_ack, dma_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_ack_owner", 32'({cpu_ack, dma_ack}), e.owner ? 32'd1 : 32'd2);
        check("sb_own_rdata",   32'(e.owner ? dma_rdata : cpu_rdata), 32'(e.own_rdata));
        check("sb_other_rdata", 32'(e.owner ? cpu_rdata : dma_rdata), 32'(e.other_rdata));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int t0, t_prev, t_ack;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    Reset = 1;
    repeat (3) tick();
    Reset = 0;
    tick();

    // Reset state
    pins("rst", 0, 0, 0, 16'h0000, 16'h0000);
    check("rst_acks",  32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);

    // Tie after reset: CPU read 0x0010 first, then DMA write 0x1234 <= 0xA5A5
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dma_req = 1; dma_we = 1; dma_addr = 16'h1234; dma_wdata = 16'hA5A5;
    sb.push_back('{OWNER_CPU, 16'hBEEF, 16'h0000});
    sb.push_back('{OWNER_DMA, 16'h0000, 16'hBEEF});
    tick();
    pins("cpu_rd_a1", 1, 1, 0, 16'h0010, 16'h0000);
    check("cpu_rd_a1_owner", 32'(owner), 32'd0);
    check("cpu_rd_a1_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    cpu_addr = 16'h0020; cpu_we = 1;   // must be ignored after grant
    tick();
    pins("cpu_rd_a2", 1, 1, 0, 16'h0010, 16'h0000);
    check("cpu_rd_a2_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    tick();
    check("cpu_rd_done_acks", 32'({cpu_ack, dma_ack}), 32'd2);
    pins("cpu_rd_done", 1, 0, 0, 16'h0010, 16'h0000);
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    pins("idle_hold", 0, 0, 0, 16'h0010, 16'h0000);
    tick();
    pins("dma_wr_a1", 1, 0, 1, 16'h1234, 16'hA5A5);
    check("dma_wr_a1_owner", 32'(owner), 32'd1);
    tick();
    pins("dma_wr_a2", 1, 0, 1, 16'h1234, 16'hA5A5);
    check("dma_wr_a2_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    tick();
    check("dma_wr_done_acks", 32'({cpu_ack, dma_ack}), 32'd1);
    dma_req = 0; dma_we = 0;
    tick();

    // Contention: both keep requesting; expect CPU, DMA, CPU, DMA every WS+3 cycles
    cpu_addr = 16'h0040; dma_addr = 16'h0080;
    sb.push_back('{OWNER_CPU, 16'hFFBF, 16'h0000});
    sb.push_back('{OWNER_DMA, 16'hFF7F, 16'hFFBF});
    sb.push_back('{OWNER_CPU, 16'hFFBF, 16'hFF7F});
    sb.push_back('{OWNER_DMA, 16'hFF7F, 16'hFFBF});
    cpu_req = 1; dma_req = 1;
    t0 = cyc;
    t_prev = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr");
      t_ack = cyc;
      if (k == 0) check("rr_latency", 32'(t_ack - t0), 32'(WS + 2));
      else        check("rr_spacing", 32'(t_ack - t_prev), 32'(WS + 3));
      t_prev = t_ack;
      if (k == 3) begin
        cpu_req = 0; dma_req = 0;
      end else if (cpu_ack) begin
        cpu_req = 0; tick(); cpu_req = 1;
      end else begin
        dma_req = 0; tick(); dma_req = 1;
      end
    end
    tick();

    // Abort: Reset in the first ACCESS cycle drops enables with no clock edge
    cpu_addr = 16'h0300; dma_addr = 16'h0300;
    cpu_req = 1; dma_req = 1;
    tick();
    check("abort_pre_oe", 32'(sram_oe), 32'd1);
    #2 Reset = 1;
    #1;
    check("abort_async_oe", 32'(sram_oe), 32'd0);
    check("abort_async_we", 32'(sram_we), 32'd0);
    check("abort_async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("abort_no_ack", 32'({cpu_ack, dma_ack}), 32'd0);
    check("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("abort_dma_rdata", 32'(dma_rdata), 32'd0);
    sb.push_back('{OWNER_CPU, 16'hFCFF, 16'h0000});
    sb.push_back('{OWNER_DMA, 16'hFCFF, 16'hFCFF});
    Reset = 0;
    tick();
    check("post_abort_busy", 32'(busy), 32'd1);
    check("post_abort_owner", 32'(owner), 32'd0);
    wait_ack("post_cpu");
    cpu_req = 0;
    wait_ack("post_dma");
    dma_req = 0;
    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
